// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_types_pkg                                              |
// | Purpose : Shared CPU datapath types: word width, word_t and aluop_t. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'hA,
    ALU_SLTU = 4'hB
  } aluop_t;

  localparam logic [4:0] c_SHAMT_MSB = 5'd4;

  // Only ADD and SUB report signed overflow; all other ops force it low.
  function automatic logic op_has_overflow(input aluop_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // SUB and SLT both need a - b from the shared adder.
  function automatic logic op_uses_sub(input aluop_t op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_if                                                     |
// | Purpose : Operand/opcode and result/flag bundle of the execute ALU.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t aluop;
  word_t  port_a;
  word_t  port_b;
  word_t  result;
  logic   negative;
  logic   zero;
  logic   overflow;

  modport master (
    output aluop,
    output port_a,
    output port_b,
    input  result,
    input  negative,
    input  zero,
    input  overflow
  );

  modport slave (
    input  aluop,
    input  port_a,
    input  port_b,
    output result,
    output negative,
    output zero,
    output overflow
  );

endinterface : alu_if
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_addsub                                                 |
// | Purpose : Shared adder a + (b ^ {W{sub}}) + sub with signed overflow.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_addsub
  import cpu_types_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  logic  i_sub,
  output word_t o_sum,
  output logic  o_overflow
);

  word_t w_b_eff;
  word_t w_sum;

  assign w_b_eff = i_b ^ {WORD_W{i_sub}};
  assign w_sum   = i_a + w_b_eff + word_t'(i_sub);

  // Overflow when both effective operands share a sign the sum does not.
  assign o_overflow = (i_a[WORD_W-1] == w_b_eff[WORD_W-1]) &&
                      (w_sum[WORD_W-1] != i_a[WORD_W-1]);
  assign o_sum      = w_sum;

endmodule : alu_addsub
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu                                                        |
// | Purpose : 32-bit execute-stage ALU with negative/zero/overflow flags.|
// |           Define ALU_OUTREG_EN to register all outputs (1 cycle).    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu
  import cpu_types_pkg::*;
(
  input  logic    CLK,
  input  logic    nRST,
  alu_if.slave    bus
);

  word_t      w_sum;
  logic       w_add_ov;
  logic       w_sub;
  logic [4:0] w_shamt;
  word_t      w_result;
  logic       w_negative;
  logic       w_zero;
  logic       w_overflow;

  assign w_sub   = op_uses_sub(bus.aluop);
  assign w_shamt = bus.port_b[c_SHAMT_MSB:0];

  alu_addsub u_addsub (
    .i_a        (bus.port_a),
    .i_b        (bus.port_b),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_overflow (w_add_ov)
  );

  always_comb begin
    w_result = '0;
    case (bus.aluop)
      ALU_SLL:  w_result = bus.port_a << w_shamt;
      ALU_SRL:  w_result = bus.port_a >> w_shamt;
      ALU_ADD:  w_result = w_sum;
      ALU_SUB:  w_result = w_sum;
      ALU_AND:  w_result = bus.port_a & bus.port_b;
      ALU_OR:   w_result = bus.port_a | bus.port_b;
      ALU_XOR:  w_result = bus.port_a ^ bus.port_b;
      ALU_NOR:  w_result = ~(bus.port_a | bus.port_b);
      // True signed compare: sign of a-b corrected by its overflow.
      ALU_SLT:  w_result = {{(WORD_W-1){1'b0}}, w_sum[WORD_W-1] ^ w_add_ov};
      ALU_SLTU: w_result = {{(WORD_W-1){1'b0}}, bus.port_a < bus.port_b};
      default:  w_result = '0;
    endcase
  end

  assign w_negative = w_result[WORD_W-1];
  assign w_zero     = (w_result == '0);
  assign w_overflow = op_has_overflow(bus.aluop) & w_add_ov;

`ifdef ALU_OUTREG_EN
  word_t r_result;
  logic  r_negative;
  logic  r_zero;
  logic  r_overflow;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_negative <= w_negative;
      r_zero     <= w_zero;
      r_overflow <= w_overflow;
    end
  end

  assign bus.result   = r_result;
  assign bus.negative = r_negative;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_overflow;
`else
  // Clock and reset have no function in the combinational build.
  logic w_unused;
  assign w_unused = &{1'b0, CLK, nRST};

  assign bus.result   = w_result;
  assign bus.negative = w_negative;
  assign bus.zero     = w_zero;
  assign bus.overflow = w_overflow;
`endif

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu                                                     |
// | Purpose : Scoreboard bench for alu; honours ALU_OUTREG_EN latency.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu;
  import cpu_types_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic [2:0]  flags;   // {negative, zero, overflow}
  } exp_t;

  logic  clk;
  logic  nrst;
  int    checks;
  int    failures;
  exp_t  sb_q[$];

  alu_if bus ();

  alu dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model built from arithmetic definitions, independent of the adder trick.
  function automatic exp_t model(input string tag, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    logic   ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    e.tag = tag;
    case (op)
      4'h0: e.result = a << b[4:0];
      4'h1: e.result = a >> b[4:0];
      4'h2: begin s = sa + sb; e.result = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h3: begin s = sa - sb; e.result = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h4: e.result = a & b;
      4'h5: e.result = a | b;
      4'h6: e.result = a ^ b;
      4'h7: e.result = ~(a | b);
      4'hA: e.result = (sa < sb) ? 32'd1 : 32'd0;
      4'hB: e.result = (a < b) ? 32'd1 : 32'd0;
      default: e.result = 32'd0;
    endcase
    e.flags = {e.result[31], e.result == 32'd0, ov};
    return e;
  endfunction

  task automatic drive(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.aluop  = aluop_t'(op);
    bus.port_a = a;
    bus.port_b = b;
    sb_q.push_back(model(tag, op, a, b));
  endtask

  task automatic sample();
    exp_t e;
`ifdef ALU_OUTREG_EN
    @(posedge clk);
`endif
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_res"}, bus.result, e.result);
      check({e.tag, "_flg"}, {29'd0, bus.negative, bus.zero, bus.overflow}, {29'd0, e.flags});
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    drive(tag, op, a, b);
    sample();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    bus.aluop  = ALU_ADD;
    bus.port_a = 32'd5;
    bus.port_b = 32'd7;

    // Reset: registered build clears outputs, combinational build ignores it.
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef ALU_OUTREG_EN
    check("rst_res", bus.result, 32'd0);
    check("rst_flg", {29'd0, bus.negative, bus.zero, bus.overflow}, 32'b010);
`else
    check("rst_res", bus.result, 32'd12);
    check("rst_flg", {29'd0, bus.negative, bus.zero, bus.overflow}, 32'b000);
`endif
    nrst = 1'b1;

    run("add_small",  4'h2, 32'd29, 32'd678978);
    run("add_ovf",    4'h2, 32'd1672548245, 32'd1875421645);
    run("sub_zero",   4'h3, 32'd1672548245, 32'd1672548245);
    run("sub_ovf",    4'h3, -32'sd1672548245, 32'd1875421645);
    run("slt_neg",    4'hA, 32'd2861325642, 32'd29);
    run("sltu_neg",   4'hB, 32'd2861325642, 32'd29);
    run("sll_3",      4'h0, 32'd1875421645, 32'd3);
    run("srl_5",      4'h1, 32'd4200100100, 32'd5);
    run("nor",        4'h7, 32'd29, 32'd678978);
    run("sll_b33",    4'h0, 32'h8000_0001, 32'd33);
    run("srl_bhi",    4'h1, 32'hF000_0000, 32'hFFFF_FFE4);
    run("slt_subov",  4'hA, 32'h8000_0000, 32'd1);
    run("slt_subov2", 4'hA, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run("and",        4'h4, 32'hF0F0_1234, 32'h0FF0_FF00);
    run("or",         4'h5, 32'h8000_0000, 32'h0000_0001);
    run("xor_zero",   4'h6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run("undef_8",    4'h8, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    run("undef_f",    4'hF, 32'h8000_0000, 32'h8000_0000);
    run("add_negov",  4'h2, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 40; i++) begin
      run($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), $urandom(), $urandom());
    end

`ifdef ALU_OUTREG_EN
    // Reset must override operands presented on the same edge.
    drive("rst_prio", 4'h7, 32'd0, 32'd0);
    void'(sb_q.pop_back());
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstp_res", bus.result, 32'd0);
    check("rstp_flg", {29'd0, bus.negative, bus.zero, bus.overflow}, 32'b010);
    nrst = 1'b1;
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_alu
`default_nettype wire
